jtopl_pg_mslot: RTL and testbench



---
 rtl/jtopl_pg_pkg.sv | 27 ++
 rtl/jtopl_pg_freq.sv | 34 +++
 rtl/jtopl_pg_mslot.sv | 124 ++++++++++++
 tb/tb_jtopl_pg_mslot.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pg_pkg.sv
// jtopl_pg_pkg: shared constants and helpers for the multi-slot phase generator.
//   FNUM_W_DEF / PH_W_DEF : default F-number and phase accumulator widths
//   SLOT_W                : width of slot indices
//   inc_width()           : width of the block-shifted increment
//   MULT_X2               : OPL MULT factors stored doubled, so MULT=0 (x0.5) stays integral
//   slot_next()           : slot counter advance with wrap at slots-1
package jtopl_pg_pkg;

    localparam int unsigned FNUM_W_DEF = 10;
    localparam int unsigned PH_W_DEF   = 19;
    localparam int unsigned SLOT_W     = 5;

    function automatic int unsigned inc_width(int unsigned fnum_w);
        return fnum_w + 7;
    endfunction

    localparam logic [4:0] MULT_X2 [16] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
    };

    function automatic logic [SLOT_W-1:0] slot_next(logic [SLOT_W-1:0] cur,
                                                    int unsigned slots);
        return (cur == SLOT_W'(slots - 1)) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/jtopl_pg_freq.sv
// jtopl_pg_freq: combinational stage-1 increment.
//   block     : octave (shift amount)
//   fnum      : F-number
//   pm_offset : signed vibrato offset
//   inc       : ((max(fnum + pm, 0)) << block) >> 1
module jtopl_pg_freq
    import jtopl_pg_pkg::*;
#(
    parameter int unsigned FNUM_W = FNUM_W_DEF,
    parameter int unsigned PM_W   = 4
) (
    input  logic [2:0]                   block,
    input  logic [FNUM_W-1:0]            fnum,
    input  logic [PM_W-1:0]              pm_offset,
    output logic [inc_width(FNUM_W)-1:0] inc
);

    localparam int unsigned INC_W = inc_width(FNUM_W);
    // Two extra bits: fnum max plus a positive offset must never read as negative.
    localparam int unsigned SUM_W = FNUM_W + 2;

    logic [SUM_W-1:0]  fsum;
    logic [FNUM_W:0]   fclamp;
    logic [INC_W:0]    shifted;

    always_comb begin
        fsum    = {2'b00, fnum} + {{(SUM_W - PM_W){pm_offset[PM_W-1]}}, pm_offset};
        // Negative sums clamp to zero instead of wrapping to a huge increment.
        fclamp  = fsum[SUM_W-1] ? '0 : fsum[FNUM_W:0];
        shifted = {7'd0, fclamp} << block;
        inc     = INC_W'(shifted >> 1);
    end

endmodule

// File: rtl/jtopl_pg_mslot.sv
// jtopl_pg_mslot: time-multiplexed phase generator for all operator slots.
//   clk, rst, cen                 : clock, sync active-high reset, clock enable
//   block, fnum, pm_offset, mul   : frequency inputs of slot slot_in
//   pg_rst                        : phase reset for slot slot_in
//   slot_in                       : slot whose inputs are sampled this cen cycle
//   phase, phase_op, slot_out     : accumulated phase (full / top 10 bits) of slot_out
// Pipeline: stage 1 increment, stage 2 MULT, stage 3 accumulate. Per-slot phase lives
// in a shift ring whose tail is the phase register itself.
module jtopl_pg_mslot
    import jtopl_pg_pkg::*;
#(
    parameter int unsigned SLOTS  = 18,
    parameter int unsigned FNUM_W = FNUM_W_DEF,
    parameter int unsigned PM_W   = 4,
    parameter int unsigned PH_W   = PH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [2:0]        block,
    input  logic [FNUM_W-1:0] fnum,
    input  logic [PM_W-1:0]   pm_offset,
    input  logic [3:0]        mul,
    input  logic              pg_rst,
    output logic [4:0]        slot_in,
    output logic [PH_W-1:0]   phase,
    output logic [9:0]        phase_op,
    output logic [4:0]        slot_out
);

    localparam int unsigned INC_W  = inc_width(FNUM_W);
    localparam int unsigned MUL_W  = FNUM_W + 11;
    // The phase register is the ring tail, so the ring itself holds SLOTS-1 entries;
    // the head then always holds the value written SLOTS cen cycles ago.
    localparam int unsigned RING_D = SLOTS - 1;

    logic [SLOT_W-1:0] slot_q;

    logic [INC_W-1:0]  inc_c, inc1_q;
    logic [3:0]        mul1_q;
    logic              rst1_q, rst2_q;
    logic [SLOT_W-1:0] tag1_q, tag2_q, tag3_q;
    logic              v1_q, v2_q, v3_q;

    logic [MUL_W:0]    prod_c;
    logic [MUL_W-1:0]  incmul_c, incmul2_q;
    logic [PH_W-1:0]   phase_c, phase_q;

    logic [PH_W-1:0]   ring_q     [RING_D];
    logic [SLOT_W-1:0] ring_tag_q [RING_D];
    logic [RING_D-1:0] ring_v_q;

    jtopl_pg_freq #(
        .FNUM_W (FNUM_W),
        .PM_W   (PM_W)
    ) u_freq (
        .block     (block),
        .fnum      (fnum),
        .pm_offset (pm_offset),
        .inc       (inc_c)
    );

    always_comb begin
        // Doubled factor then halve: covers MULT=0 (x0.5) without a special case.
        prod_c   = (MUL_W + 1)'(inc1_q) * (MUL_W + 1)'(MULT_X2[mul1_q]);
        incmul_c = MUL_W'(prod_c >> 1);
        phase_c  = rst2_q ? '0 : ring_q[0] + PH_W'(incmul2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '0;
            inc1_q    <= '0;
            mul1_q    <= '0;
            rst1_q    <= 1'b0;
            tag1_q    <= '0;
            v1_q      <= 1'b0;
            incmul2_q <= '0;
            rst2_q    <= 1'b0;
            tag2_q    <= '0;
            v2_q      <= 1'b0;
            phase_q   <= '0;
            tag3_q    <= '0;
            v3_q      <= 1'b0;
            ring_v_q  <= '0;
            for (int i = 0; i < RING_D; i++) begin
                ring_q[i]     <= '0;
                ring_tag_q[i] <= '0;
            end
        end else if (cen) begin
            slot_q    <= slot_next(slot_q, SLOTS);
            inc1_q    <= inc_c;
            mul1_q    <= mul;
            rst1_q    <= pg_rst;
            tag1_q    <= slot_q;
            v1_q      <= 1'b1;
            incmul2_q <= incmul_c;
            rst2_q    <= rst1_q;
            tag2_q    <= tag1_q;
            v2_q      <= v1_q;
            phase_q   <= phase_c;
            tag3_q    <= tag2_q;
            v3_q      <= v2_q;
            for (int i = 0; i < RING_D - 1; i++) begin
                ring_q[i]     <= ring_q[i+1];
                ring_tag_q[i] <= ring_tag_q[i+1];
                ring_v_q[i]   <= ring_v_q[i+1];
            end
            ring_q[RING_D-1]     <= phase_q;
            ring_tag_q[RING_D-1] <= tag3_q;
            ring_v_q[RING_D-1]   <= v3_q;
        end
    end

    // The ring head must always belong to the slot currently in stage 3.
    ring_align: assert property (@(posedge clk) disable iff (rst)
        (cen && v2_q && ring_v_q[0]) |-> (ring_tag_q[0] == tag2_q));

    assign slot_in  = slot_q;
    assign slot_out = tag3_q;
    assign phase    = phase_q;
    assign phase_op = phase_q[PH_W-1 -: 10];

endmodule

// File: tb/tb_jtopl_pg_mslot.sv
// Testbench for jtopl_pg_mslot: per-slot configuration tables drive the DUT, a
// behavioural model keeps one phase per slot plus a 3-deep latency queue.
module tb_jtopl_pg_mslot;

    localparam int SLOTS  = 18;
    localparam int FNUM_W = 10;
    localparam int PM_W   = 4;
    localparam int PH_W   = 19;

    logic              clk = 1'b0;
    logic              rst, cen, pg_rst;
    logic [2:0]        block;
    logic [FNUM_W-1:0] fnum;
    logic [PM_W-1:0]   pm_offset;
    logic [3:0]        mul;
    logic [4:0]        slot_in, slot_out;
    logic [PH_W-1:0]   phase;
    logic [9:0]        phase_op;

    jtopl_pg_mslot #(
        .SLOTS  (SLOTS),
        .FNUM_W (FNUM_W),
        .PM_W   (PM_W),
        .PH_W   (PH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .block     (block),
        .fnum      (fnum),
        .pm_offset (pm_offset),
        .mul       (mul),
        .pg_rst    (pg_rst),
        .slot_in   (slot_in),
        .phase     (phase),
        .phase_op  (phase_op),
        .slot_out  (slot_out)
    );

    always #5 clk = ~clk;

    // Per-slot configuration
    int cf_fnum [SLOTS];
    int cf_block[SLOTS];
    int cf_pm   [SLOTS];
    int cf_mul  [SLOTS];
    bit cf_rst  [SLOTS];

    // Reference model
    longint m_ph[SLOTS];
    int     m_slot, m_edges;
    int     q_slot[$];
    longint q_ph[$];
    logic [4:0]      e_si, e_so;
    logic [PH_W-1:0] e_ph;
    logic [9:0]      e_op;
    bit              e_valid;

    // DUT phases observed per slot (indexed by the model's expected slot)
    int unsigned obs_ph[SLOTS][$];
    int unsigned obs_op[SLOTS][$];

    int checks = 0;
    int errors = 0;

    function automatic longint apply_mul(longint inc, int m);
        if (m == 0)  return inc / 2;
        if (m <= 10) return inc * m;
        if (m == 11) return inc * 10;
        if (m <= 13) return inc * 12;
        return inc * 15;
    endfunction

    task automatic clear_cfg();
        for (int s = 0; s < SLOTS; s++) begin
            cf_fnum[s] = 0; cf_block[s] = 0; cf_pm[s] = 0; cf_mul[s] = 1; cf_rst[s] = 0;
            obs_ph[s].delete(); obs_op[s].delete();
        end
    endtask

    task automatic cycle(input bit r, input bit c);
        int s;
        longint f, inc, np;
        @(negedge clk);
        rst = r;
        cen = c;
        s = m_slot;
        if (c || r) begin
            fnum = FNUM_W'(cf_fnum[s]); block = 3'(cf_block[s]); pm_offset = PM_W'(cf_pm[s]);
            mul = 4'(cf_mul[s]); pg_rst = cf_rst[s];
        end else begin
            fnum = FNUM_W'($urandom); block = 3'($urandom); pm_offset = PM_W'($urandom);
            mul = 4'($urandom); pg_rst = 1'($urandom);
        end
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        if (r) begin
            for (int i = 0; i < SLOTS; i++) m_ph[i] = 0;
            q_slot.delete(); q_ph.delete();
            m_slot = 0; m_edges = 0;
            e_so = '0; e_ph = '0;
        end else if (c) begin
            f = longint'(cf_fnum[s]) + longint'(cf_pm[s]);
            if (f < 0) f = 0;
            inc = (f << cf_block[s]) >> 1;
            np = cf_rst[s] ? 0 : (m_ph[s] + apply_mul(inc, cf_mul[s])) % (64'd1 << PH_W);
            cf_rst[s] = 0;
            m_ph[s] = np;
            q_slot.push_back(s);
            q_ph.push_back(np);
            if (q_slot.size() == 3) begin
                e_so = 5'(q_slot.pop_front());
                e_ph = PH_W'(q_ph.pop_front());
                e_valid = 1'b1;
                obs_ph[e_so].push_back(phase);
                obs_op[e_so].push_back(phase_op);
            end
            m_slot = (m_slot + 1) % SLOTS;
            m_edges++;
        end
        e_si = 5'(m_slot);
        e_op = e_ph[PH_W-1 -: 10];
    endtask

    task automatic test_reset();
        clear_cfg();
        cycle(1, 1);
        cycle(1, 1);
        checks++;
        if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
            errors++;
            $display("FAIL reset_state: got si=%0d so=%0d ph=%0d op=%0d want 0 0 0 0",
                     slot_in, slot_out, phase, phase_op);
        end
        cf_fnum[4] = 'h200; cf_block[4] = 7; cf_mul[4] = 15;
        for (int k = 0; k < 10; k++) cycle(0, 1);
        cycle(1, 0);  // reset must win over cen=0
        checks++;
        if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
            errors++;
            $display("FAIL reset_no_cen: got si=%0d so=%0d ph=%0d op=%0d want 0 0 0 0",
                     slot_in, slot_out, phase, phase_op);
        end
    endtask

    task automatic test_basic();
        int unsigned want[4] = '{0, 2048, 4096, 6144};
        clear_cfg();
        cf_fnum[0] = 'h100; cf_block[0] = 4; cf_rst[0] = 1;
        cycle(1, 1);
        for (int k = 0; k < 4 * SLOTS + 3; k++) begin
            cycle(0, 1);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL basic_cycle: got si=%0d so=%0d ph=%0d want si=%0d so=%0d ph=%0d",
                         slot_in, slot_out, phase, e_si, e_so, e_ph);
            end
        end
        checks++;
        if (obs_ph[0].size() < 4) begin
            errors++;
            $display("FAIL basic_visits: got %0d visits want 4", obs_ph[0].size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_ph[0][i] != want[i]) begin
                    errors++;
                    $display("FAIL basic_seq[%0d]: got %0d want %0d", i, obs_ph[0][i], want[i]);
                end
            end
        end
        checks++;
        if (obs_ph[1].size() == 0 || obs_ph[1][obs_ph[1].size()-1] != 0) begin
            errors++;
            $display("FAIL basic_other_slot: slot 1 phase not 0");
        end
    endtask

    task automatic test_clamp();
        int n;
        clear_cfg();
        cf_fnum[3] = 'h100; cf_block[3] = 4;
        cycle(1, 1);
        for (int k = 0; k < SLOTS; k++) cycle(0, 1);
        cf_fnum[3] = 0; cf_pm[3] = -1; cf_block[3] = 7;
        for (int k = 0; k < 3 * SLOTS; k++) begin
            cycle(0, 1);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL clamp_cycle: got so=%0d ph=%0d want so=%0d ph=%0d",
                         slot_out, phase, e_so, e_ph);
            end
        end
        n = obs_ph[3].size();
        checks++;
        if (n < 3 || obs_ph[3][n-1] != 2048 || obs_ph[3][n-2] != 2048) begin
            errors++;
            $display("FAIL clamp_hold: got last=%0d want 2048", (n > 0) ? obs_ph[3][n-1] : 0);
        end
    endtask

    task automatic test_max_mul15();
        clear_cfg();
        cf_fnum[2] = 1023; cf_pm[2] = 7; cf_block[2] = 7; cf_mul[2] = 15; cf_rst[2] = 1;
        cycle(1, 1);
        for (int k = 0; k < 2 * SLOTS + 3; k++) cycle(0, 1);
        checks++;
        if (obs_ph[2].size() < 2 || obs_ph[2][0] != 0 || obs_ph[2][1] != 464512
            || obs_op[2][1] != 907) begin
            errors++;
            $display("FAIL max_mul15: got ph=%0d op=%0d want ph=464512 op=907",
                     (obs_ph[2].size() > 1) ? obs_ph[2][1] : 0,
                     (obs_op[2].size() > 1) ? obs_op[2][1] : 0);
        end
    endtask

    task automatic test_mul_table();
        int          muls[3] = '{0, 11, 13};
        int unsigned want[3] = '{1024, 20480, 24576};
        for (int i = 0; i < 3; i++) begin
            clear_cfg();
            cf_fnum[1] = 'h100; cf_block[1] = 4; cf_mul[1] = muls[i]; cf_rst[1] = 1;
            cycle(1, 1);
            for (int k = 0; k < 2 * SLOTS + 3; k++) cycle(0, 1);
            checks++;
            if (obs_ph[1].size() < 2 || obs_ph[1][0] != 0 || obs_ph[1][1] != want[i]) begin
                errors++;
                $display("FAIL mul_%0d: got %0d want %0d", muls[i],
                         (obs_ph[1].size() > 1) ? obs_ph[1][1] : 0, want[i]);
            end
        end
    endtask

    task automatic test_interleave();
        clear_cfg();
        cf_fnum[5] = 'h155; cf_block[5] = 3; cf_mul[5] = 2;
        cf_fnum[6] = 'h2AA; cf_block[6] = 5; cf_mul[6] = 3;
        cycle(1, 1);
        for (int fr = 0; fr < 6; fr++) begin
            if (fr % 2 == 1) cf_rst[5] = 1;
            for (int k = 0; k < SLOTS; k++) begin
                cycle(0, 1);
                checks++;
                if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                    errors++;
                    $display("FAIL interleave_cycle: got so=%0d ph=%0d want so=%0d ph=%0d",
                             slot_out, phase, e_so, e_ph);
                end
                if (m_edges >= 3) begin
                    checks++;
                    if (int'(slot_out) != (int'(slot_in) + SLOTS - 3) % SLOTS) begin
                        errors++;
                        $display("FAIL slot_offset: got so=%0d si=%0d", slot_out, slot_in);
                    end
                end
            end
        end
        checks++;
        if (obs_ph[6].size() < 4 || obs_ph[6][3] <= obs_ph[6][2]) begin
            errors++;
            $display("FAIL interleave_slot6: slot 6 not accumulating");
        end
    endtask

    task automatic test_midframe_reset();
        for (int s = 0; s < SLOTS; s++) begin
            cf_fnum[s] = $urandom_range(0, 1023); cf_block[s] = $urandom_range(0, 7);
            cf_mul[s] = $urandom_range(0, 15); cf_pm[s] = 0;
        end
        for (int k = 0; k < SLOTS + 5; k++) cycle(0, 1);
        for (int k = 0; k < SLOTS && m_slot != 9; k++) cycle(0, 1);
        cycle(1, 1);
        checks++;
        if ({slot_in, slot_out, phase} !== 29'd0) begin
            errors++;
            $display("FAIL midframe_reset: got si=%0d so=%0d ph=%0d want 0 0 0",
                     slot_in, slot_out, phase);
        end
        cycle(0, 1);
        checks++;
        if (slot_in !== 5'd1) begin
            errors++;
            $display("FAIL midframe_restart: got si=%0d want 1", slot_in);
        end
        for (int k = 0; k < 2 * SLOTS; k++) begin
            cycle(0, 1);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL midframe_cycle: got so=%0d ph=%0d want so=%0d ph=%0d",
                         slot_out, phase, e_so, e_ph);
            end
        end
    endtask

    task automatic test_cen_hold();
        for (int k = 0; k < 7; k++) cycle(0, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL cen_hold: got si=%0d so=%0d ph=%0d want si=%0d so=%0d ph=%0d",
                         slot_in, slot_out, phase, e_si, e_so, e_ph);
            end
        end
        for (int k = 0; k < 2 * SLOTS; k++) begin
            cycle(0, 1);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL cen_resume: got so=%0d ph=%0d want so=%0d ph=%0d",
                         slot_out, phase, e_so, e_ph);
            end
        end
    endtask

    task automatic test_random();
        bit r, c;
        int s;
        clear_cfg();
        cycle(1, 1);
        for (int k = 0; k < 600; k++) begin
            s = $urandom_range(0, SLOTS - 1);
            cf_fnum[s] = $urandom_range(0, 1023); cf_block[s] = $urandom_range(0, 7);
            cf_pm[s] = $urandom_range(0, 15) - 8; cf_mul[s] = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) cf_rst[$urandom_range(0, SLOTS - 1)] = 1;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 4) != 0);
            cycle(r, c);
            checks++;
            if ({slot_in, slot_out, phase, phase_op} !== {e_si, e_so, e_ph, e_op}) begin
                errors++;
                $display("FAIL random_cycle %0d: got si=%0d so=%0d ph=%0d want si=%0d so=%0d ph=%0d",
                         k, slot_in, slot_out, phase, e_si, e_so, e_ph);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; pg_rst = 1'b0; block = '0; fnum = '0; pm_offset = '0; mul = '0;
        m_slot = 0; m_edges = 0;
        test_reset();
        test_basic();
        test_clamp();
        test_max_mul15();
        test_mul_table();
        test_interleave();
        test_midframe_reset();
        test_cen_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
